pipe_ctrl: RTL and testbench

- Pipeline control unit; the source of the `stall[5:0]` vector and the `flush` signal that every stage register (pc, if/id, id/ex, ex/mem, mem/wb) consumes.
- Merges stall requests from ID, EX and MEM into one stall vector.
- Runs a two-cycle exception flush sequence and supplies the redirect PC.
- Keeps stall and flush performance counters.

---
 rtl/pipe_ctrl_if.sv | 28 ++
 rtl/pipe_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall-request / exception inputs and stall, flush, redirect
// and counter outputs of the pipeline control unit.
interface pipe_ctrl_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic        clr_cnt;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  logic        stall_timeout;

  modport master (
    output stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype, cp0_epc, clr_cnt,
    input  stall, flush, new_pc, stall_cycles, flush_count, stall_timeout
  );

  modport slave (
    input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype, cp0_epc, clr_cnt,
    output stall, flush, new_pc, stall_cycles, flush_count, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges ID/EX/MEM stall requests into the stage stall vector,
// runs the two-cycle exception flush with redirect PC, and keeps stall and
// flush performance counters.
// Optional stall watchdog: define PIPE_CTRL_STALL_WDT_EN.
module pipe_ctrl #(
  parameter logic [31:0] INT_VECTOR = 32'h0000_0020,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter int unsigned WDT_LIMIT  = 1024
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [31:0] ERET_CODE = 32'h0000_000e;
  localparam logic [31:0] INT_CODE  = 32'h0000_0001;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc_q;
  logic [31:0] pc_sel;
  logic [5:0]  stall_c;
  logic        flush_c;
  logic [31:0] new_pc_c;
  logic        accept_c;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        timeout_q;

  // A zero limit would make the watchdog meaningless
  if (WDT_LIMIT == 0) begin : g_limit_chk
    $error("WDT_LIMIT must be nonzero");
  end

  // Redirect target for the exception presented this cycle
  always_comb begin
    pc_sel = EXC_VECTOR;
    if (bus.excepttype == ERET_CODE) begin
      pc_sel = bus.cp0_epc;
    end else if (bus.excepttype == INT_CODE) begin
      pc_sel = INT_VECTOR;
    end
  end

  // Next state and zero-latency stall/flush/redirect outputs
  always_comb begin
    state_nx = state;
    stall_c  = '0;
    flush_c  = 1'b0;
    new_pc_c = '0;
    accept_c = 1'b0;
    case (state)
      IDLE: begin
        if (bus.excepttype != '0) begin
          flush_c  = 1'b1;
          new_pc_c = pc_sel;
          accept_c = 1'b1;
          state_nx = FLUSH;
        end else if (bus.stallreq_from_mem) begin
          stall_c = 6'b011111;
        end else if (bus.stallreq_from_ex) begin
          stall_c = 6'b001111;
        end else if (bus.stallreq_from_id) begin
          stall_c = 6'b000111;
        end
      end
      FLUSH: begin
        flush_c  = 1'b1;
        new_pc_c = pc_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and captured redirect PC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept_c) pc_q <= pc_sel;
    end
  end

  // Performance counters; clear beats a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (bus.clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_c[0] && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (accept_c) flush_cnt <= flush_cnt + 16'd1;
    end
  end

`ifdef PIPE_CTRL_STALL_WDT_EN
  logic [31:0] wdt_cnt;

  // Consecutive-stall watchdog; timeout is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_cnt   <= '0;
      timeout_q <= 1'b0;
    end else if (!stall_c[0] || flush_c) begin
      wdt_cnt <= '0;
    end else begin
      if (wdt_cnt < 32'(WDT_LIMIT)) wdt_cnt <= wdt_cnt + 32'd1;
      if (wdt_cnt >= 32'(WDT_LIMIT - 1)) timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_q = 1'b0;
`endif

  assign bus.stall         = stall_c;
  assign bus.flush         = flush_c;
  assign bus.new_pc        = new_pc_c;
  assign bus.stall_cycles  = stall_cnt;
  assign bus.flush_count   = flush_cnt;
  assign bus.stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven vectors for pipe_ctrl plus hand sequences for
// async reset mid-flush, stall counter saturation/clear and the watchdog.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_STALL_WDT_EN
  localparam int unsigned WDT_LIM = 4;
  localparam logic        WDT_EXP = 1'b1;
`else
  localparam int unsigned WDT_LIM = 1024;
  localparam logic        WDT_EXP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .INT_VECTOR(32'h0000_0020),
    .EXC_VECTOR(32'h0000_0040),
    .WDT_LIMIT (WDT_LIM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic        ex;
    logic        mem;
    logic [31:0] exc;
    logic [31:0] epc;
    logic        clr;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic [31:0] e_sc;
    logic [15:0] e_fc;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(logic id, logic ex, logic mem, logic [31:0] exc,
                              logic [31:0] epc, logic clr, logic [5:0] st,
                              logic fl, logic [31:0] pc, logic [31:0] sc,
                              logic [15:0] fc);
    vec_t v;
    v.id = id; v.ex = ex; v.mem = mem; v.exc = exc; v.epc = epc; v.clr = clr;
    v.e_stall = st; v.e_flush = fl; v.e_pc = pc; v.e_sc = sc; v.e_fc = fc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic id, input logic ex, input logic mem,
                       input logic [31:0] exc, input logic [31:0] epc, input logic clr);
    bus.stallreq_from_id  = id;
    bus.stallreq_from_ex  = ex;
    bus.stallreq_from_mem = mem;
    bus.excepttype        = exc;
    bus.cp0_epc           = epc;
    bus.clr_cnt           = clr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0, 0);

    //          id ex mem exc          epc          clr stall      fl pc           sc  fc
    vecs[0]  = mk(0, 0, 0, 32'h0,       32'h0,       0, 6'b000000, 0, 32'h0,       0, 0);
    vecs[1]  = mk(0, 1, 0, 32'h0,       32'h0,       0, 6'b001111, 0, 32'h0,       0, 0);
    vecs[2]  = mk(0, 1, 0, 32'h0,       32'h0,       0, 6'b001111, 0, 32'h0,       1, 0);
    vecs[3]  = mk(0, 1, 0, 32'h0,       32'h0,       0, 6'b001111, 0, 32'h0,       2, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0,       32'h0,       0, 6'b000000, 0, 32'h0,       3, 0);
    vecs[5]  = mk(1, 0, 1, 32'h0,       32'h0,       0, 6'b011111, 0, 32'h0,       3, 0);
    vecs[6]  = mk(1, 0, 0, 32'h0,       32'h0,       0, 6'b000111, 0, 32'h0,       4, 0);
    vecs[7]  = mk(1, 1, 0, 32'h0,       32'h0,       0, 6'b001111, 0, 32'h0,       5, 0);
    vecs[8]  = mk(0, 0, 1, 32'he,       32'h80000100,0, 6'b000000, 1, 32'h80000100,6, 0);
    vecs[9]  = mk(0, 0, 1, 32'h0,       32'h0,       0, 6'b000000, 1, 32'h80000100,6, 1);
    vecs[10] = mk(0, 0, 0, 32'h0,       32'h0,       0, 6'b000000, 0, 32'h0,       6, 1);
    vecs[11] = mk(0, 0, 0, 32'h1,       32'h0,       0, 6'b000000, 1, 32'h20,      6, 1);
    vecs[12] = mk(0, 0, 0, 32'h1,       32'h0,       0, 6'b000000, 1, 32'h20,      6, 2);
    vecs[13] = mk(0, 0, 0, 32'h1,       32'h0,       0, 6'b000000, 1, 32'h20,      6, 2);
    vecs[14] = mk(0, 1, 0, 32'h1,       32'h0,       0, 6'b000000, 1, 32'h20,      6, 3);
    vecs[15] = mk(0, 0, 0, 32'h5,       32'h0,       0, 6'b000000, 1, 32'h40,      6, 3);
    vecs[16] = mk(0, 0, 0, 32'h0,       32'h0,       0, 6'b000000, 1, 32'h40,      6, 4);
    vecs[17] = mk(0, 1, 0, 32'h0,       32'h0,       1, 6'b001111, 0, 32'h0,       6, 4);
    vecs[18] = mk(0, 0, 0, 32'h0,       32'h0,       0, 6'b000000, 0, 32'h0,       0, 0);
    vecs[19] = mk(0, 0, 0, 32'he,       32'h1234,    0, 6'b000000, 1, 32'h1234,    0, 0);
    vecs[20] = mk(0, 0, 0, 32'h0,       32'h5678,    0, 6'b000000, 1, 32'h1234,    0, 1);
    vecs[21] = mk(0, 0, 0, 32'h0,       32'h0,       0, 6'b000000, 0, 32'h0,       0, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset stall", 32'(bus.stall), 32'h0);
    check("reset flush", 32'(bus.flush), 32'h0);
    check("reset new_pc", bus.new_pc, 32'h0);
    check("reset stall_cycles", bus.stall_cycles, 32'h0);
    check("reset flush_count", 32'(bus.flush_count), 32'h0);
    check("reset stall_timeout", 32'(bus.stall_timeout), 32'h0);

    // Table of per-cycle vectors, sampled before the next rising edge
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].id, vecs[i].ex, vecs[i].mem, vecs[i].exc, vecs[i].epc, vecs[i].clr);
      #1;
      check($sformatf("v%0d stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
      check($sformatf("v%0d flush", i), 32'(bus.flush), 32'(vecs[i].e_flush));
      check($sformatf("v%0d new_pc", i), bus.new_pc, vecs[i].e_pc);
      check($sformatf("v%0d stall_cycles", i), bus.stall_cycles, vecs[i].e_sc);
      check($sformatf("v%0d flush_count", i), 32'(bus.flush_count), 32'(vecs[i].e_fc));
    end

    // Async reset in the middle of a flush drops flush without an edge
    @(negedge clk);
    drive(0, 0, 0, 32'h1, 32'h0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 32'h0, 32'h0, 0);
    #1;
    check("mid-flush flush", 32'(bus.flush), 32'h1);
    check("mid-flush new_pc", bus.new_pc, 32'h20);
    rst = 1'b1;
    #1;
    check("async rst flush", 32'(bus.flush), 32'h0);
    check("async rst new_pc", bus.new_pc, 32'h0);
    check("async rst flush_count", 32'(bus.flush_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Stall counter saturation, then clear beating an increment
    @(negedge clk);
    drive(0, 1, 0, 32'h0, 32'h0, 0);
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    repeat (2) @(negedge clk);
    #1;
    check("stall_cycles saturate", bus.stall_cycles, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    #1;
    check("stall_cycles hold", bus.stall_cycles, 32'hFFFF_FFFF);
    bus.clr_cnt = 1'b1;
    @(negedge clk);
    bus.clr_cnt = 1'b0;
    bus.stallreq_from_ex = 1'b0;
    #1;
    check("stall_cycles clear", bus.stall_cycles, 32'h0);

    // Watchdog: 3 stalled, 1 free, 3 stalled must not time out
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        bus.stallreq_from_ex = 1'b1;
      end
      @(negedge clk);
      bus.stallreq_from_ex = 1'b0;
    end
    #1;
    check("wdt 3+3 no timeout", 32'(bus.stall_timeout), 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.stallreq_from_ex = 1'b1;
    end
    @(negedge clk);
    bus.stallreq_from_ex = 1'b0;
    #1;
    check("wdt 4 cycles", 32'(bus.stall_timeout), 32'(WDT_EXP));
    bus.clr_cnt = 1'b1;
    @(negedge clk);
    bus.clr_cnt = 1'b0;
    @(negedge clk);
    #1;
    check("wdt sticky over clr", 32'(bus.stall_timeout), 32'(WDT_EXP));
    check("stall_cycles after clr", bus.stall_cycles, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
